// File: rtl/sa_feeder_pkg.sv
// Shared state encoding for the systolic-array feeder.
package sa_feeder_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRELOAD,
    ST_SETTLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } sa_state_e;

endpackage

// File: rtl/sa_lane_delay.sv
// Per-lane shift register; DEPTH of zero is a plain wire.
module sa_lane_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, shift_i};
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] sr_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
        end else if (shift_i) begin
          sr_q[0] <= d_i;
          for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
        end
      end

      assign q_o = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Sequences one tile pass into the systolic array: ifmap preload burst,
// then skewed weight stream with psum enables held for the whole pass.
//
// state   | meaning
// IDLE    | waiting for start_i
// LOAD    | accepting PE_SIZE ifmap rows into the buffer
// PRELOAD | replaying buffered rows back-to-back
// SETTLE  | PE_SIZE cycles of zero ifmap rows
// STREAM  | accepting weight vectors until the count is reached
// DRAIN   | PE_SIZE cycles flushing the skew chain
// DONE    | one-cycle done pulse
module sa_feeder
  import sa_feeder_pkg::*;
#(
  parameter int PE_SIZE    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [CNT_W-1:0]               num_cols_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0]  ifmap_row_i,
  input  logic                           ifmap_valid_i,
  output logic                           ifmap_ready_o,
  input  logic [DATA_WIDTH*PE_SIZE-1:0]  weight_row_i,
  input  logic                           weight_valid_i,
  output logic                           weight_ready_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0]  ifmap_row_o,
  output logic                           ifmap_preload_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0]  weight_col_o,
  output logic [PE_SIZE-1:0]             weight_en_col_o,
  output logic [PSUM_WIDTH*PE_SIZE-1:0]  psum_row_o,
  output logic [PE_SIZE-1:0]             psum_en_row_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int ROW_W = DATA_WIDTH * PE_SIZE;
  localparam int IDX_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_SIZE - 1);

  sa_state_e          state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, timer_q, rd_idx;
  logic [CNT_W-1:0]   cols_left_q;
  logic [ROW_W-1:0]   row_buf_q [PE_SIZE];
  logic [ROW_W-1:0]   ifmap_row_q;
  logic               preload_q, psum_en_q;
  logic [ROW_W-1:0]   s0_data_q;
  logic [PE_SIZE-1:0] s0_en_q;
  logic               ifmap_acc, weight_acc, shift_en;

  assign ifmap_ready_o   = (state_q == ST_LOAD);
  assign weight_ready_o  = (state_q == ST_STREAM) && (cols_left_q != '0);
  assign ifmap_acc       = ifmap_valid_i & ifmap_ready_o;
  assign weight_acc      = weight_valid_i & weight_ready_o;
  assign shift_en        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign ifmap_row_o     = ifmap_row_q;
  assign ifmap_preload_o = preload_q;
  assign psum_row_o      = '0;
  assign psum_en_row_o   = {PE_SIZE{psum_en_q}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_LOAD;
      ST_LOAD:    if (ifmap_acc && ptr_q == LAST_IDX) state_d = ST_PRELOAD;
      ST_PRELOAD: if (timer_q == '0) state_d = ST_SETTLE;
      ST_SETTLE:  if (timer_q == '0) state_d = (cols_left_q == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM:  if (weight_acc && cols_left_q == CNT_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN:   if (timer_q == '0) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output row is registered, so look one row ahead of the one being shown.
  always_comb begin
    rd_idx = '0;
    if (state_q == ST_PRELOAD) rd_idx = IDX_W'(PE_SIZE - int'(timer_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      timer_q     <= '0;
      cols_left_q <= '0;
      ifmap_row_q <= '0;
      preload_q   <= 1'b0;
      psum_en_q   <= 1'b0;
      s0_data_q   <= '0;
      s0_en_q     <= '0;
      for (int r = 0; r < PE_SIZE; r++) row_buf_q[r] <= '0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q)      timer_q <= LAST_IDX;
      else if (timer_q != '0)      timer_q <= timer_q - IDX_W'(1);

      if (ifmap_acc) begin
        row_buf_q[ptr_q] <= ifmap_row_i;
        ptr_q <= (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
      end else if (state_q == ST_IDLE) begin
        ptr_q <= '0;
      end

      if (state_q == ST_IDLE && start_i) cols_left_q <= num_cols_i;
      else if (weight_acc)               cols_left_q <= cols_left_q - CNT_W'(1);

      ifmap_row_q <= (state_d == ST_PRELOAD) ? row_buf_q[rd_idx] : '0;
      preload_q   <= (state_d == ST_PRELOAD) && (state_q != ST_PRELOAD);
      psum_en_q   <= weight_acc | (psum_en_q & shift_en);

      if (shift_en) begin
        s0_data_q <= weight_acc ? weight_row_i : '0;
        s0_en_q   <= {PE_SIZE{weight_acc}};
      end
    end
  end

  // Lane i sits PE_SIZE-1-i stages behind the entry register.
  generate
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
      logic [DATA_WIDTH:0] lane_q;

      sa_lane_delay #(
        .DEPTH(PE_SIZE - 1 - i),
        .WIDTH(DATA_WIDTH + 1)
      ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .shift_i(shift_en),
        .d_i    ({s0_en_q[i], s0_data_q[i*DATA_WIDTH +: DATA_WIDTH]}),
        .q_o    (lane_q)
      );

      assign weight_en_col_o[i]                       = lane_q[DATA_WIDTH];
      assign weight_col_o[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[DATA_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder: preload burst, weight skew, bubbles, empty pass, reset.
module tb_sa_feeder;

  localparam int PE = 4;
  localparam int DW = 8;
  localparam int PW = 32;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start_i = 1'b0;
  logic [CW-1:0]   num_cols_i = '0;
  logic [DW*PE-1:0] ifmap_row_i = '0;
  logic            ifmap_valid_i = 1'b0;
  logic            ifmap_ready_o;
  logic [DW*PE-1:0] weight_row_i = '0;
  logic            weight_valid_i = 1'b0;
  logic            weight_ready_o;
  logic [DW*PE-1:0] ifmap_row_o;
  logic            ifmap_preload_o;
  logic [DW*PE-1:0] weight_col_o;
  logic [PE-1:0]   weight_en_col_o;
  logic [PW*PE-1:0] psum_row_o;
  logic [PE-1:0]   psum_en_row_o;
  logic            busy_o;
  logic            done_o;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_col [16];
  logic [3:0]  exp_en  [16];
  logic        in_v    [16];
  logic [31:0] in_d    [16];
  logic        in_s    [16];

  sa_feeder #(.PE_SIZE(PE), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .num_cols_i     (num_cols_i),
    .ifmap_row_i    (ifmap_row_i),
    .ifmap_valid_i  (ifmap_valid_i),
    .ifmap_ready_o  (ifmap_ready_o),
    .weight_row_i   (weight_row_i),
    .weight_valid_i (weight_valid_i),
    .weight_ready_o (weight_ready_o),
    .ifmap_row_o    (ifmap_row_o),
    .ifmap_preload_o(ifmap_preload_o),
    .weight_col_o   (weight_col_o),
    .weight_en_col_o(weight_en_col_o),
    .psum_row_o     (psum_row_o),
    .psum_en_row_o  (psum_en_row_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_iready"}, ifmap_ready_o, 0);
    check({tag, "_wready"}, weight_ready_o, 0);
    check({tag, "_irow"}, ifmap_row_o, 0);
    check({tag, "_preload"}, ifmap_preload_o, 0);
    check({tag, "_wcol"}, weight_col_o, 0);
    check({tag, "_wen"}, weight_en_col_o, 0);
    check({tag, "_psum"}, psum_row_o, 0);
    check({tag, "_psum_en"}, psum_en_row_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  task automatic start_pass(input logic [CW-1:0] n);
    start_i    = 1'b1;
    num_cols_i = n;
    cyc();
    start_i    = 1'b0;
  endtask

  task automatic load_rows();
    for (int r = 0; r < PE; r++) begin
      ifmap_valid_i = 1'b1;
      ifmap_row_i   = 32'h11111111 * (r + 1);
      cyc();
    end
    ifmap_valid_i = 1'b0;
  endtask

  // Ends on the first STREAM cycle when n > 0.
  task automatic load_fast(input logic [CW-1:0] n);
    start_pass(n);
    load_rows();
    repeat (2 * PE) cyc();
  endtask

  task automatic clear_table();
    for (int t = 0; t < 16; t++) begin
      exp_col[t] = '0; exp_en[t] = '0; in_v[t] = 1'b0; in_d[t] = '0; in_s[t] = 1'b0;
    end
  endtask

  task automatic run_stream(input string tag, input int len, input int done_t, input int ready_last);
    for (int t = 0; t < len; t++) begin
      check($sformatf("%s_col%0d", tag, t), weight_col_o, exp_col[t]);
      check($sformatf("%s_en%0d", tag, t), weight_en_col_o, exp_en[t]);
      check($sformatf("%s_psen%0d", tag, t), psum_en_row_o, {PE{(t >= 1) && (t <= done_t)}});
      check($sformatf("%s_psum%0d", tag, t), psum_row_o, 0);
      check($sformatf("%s_done%0d", tag, t), done_o, t == done_t);
      check($sformatf("%s_busy%0d", tag, t), busy_o, t <= done_t);
      check($sformatf("%s_rdy%0d", tag, t), weight_ready_o, t <= ready_last);
      weight_valid_i = in_v[t];
      weight_row_i   = in_d[t];
      start_i        = in_s[t];
      num_cols_i     = in_s[t] ? 8'd8 : num_cols_i;
      cyc();
    end
    weight_valid_i = 1'b0;
    start_i        = 1'b0;
  endtask

  initial begin
    logic [31:0] rows [4];
    int          gaps [4];
    logic [31:0] pre_row [8];

    // 1: asynchronous reset asserted mid-clock
    #7 rst_n = 1'b0;
    #1 check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check_quiet("idle");

    // 2: preload burst with gaps on the ifmap side
    start_pass(8'd4);
    check("load_busy", busy_o, 1);
    check("load_iready", ifmap_ready_o, 1);
    check("load_wready", weight_ready_o, 0);
    rows = '{32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    gaps = '{1, 2, 0, 0};
    for (int r = 0; r < 4; r++) begin
      ifmap_valid_i = 1'b1;
      ifmap_row_i   = rows[r];
      cyc();
      ifmap_valid_i = 1'b0;
      ifmap_row_i   = 32'hdeadbeef;
      for (int g = 0; g < gaps[r]; g++) begin
        check($sformatf("gap%0d_preload", r), ifmap_preload_o, 0);
        check($sformatf("gap%0d_irow", r), ifmap_row_o, 0);
        cyc();
      end
    end
    pre_row = '{32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pre%0d_row", k), ifmap_row_o, pre_row[k]);
      check($sformatf("pre%0d_flag", k), ifmap_preload_o, k == 0);
      check($sformatf("pre%0d_iready", k), ifmap_ready_o, 0);
      cyc();
    end

    // 3: back-to-back weights through the skew
    clear_table();
    exp_col = '{0, 32'h01000000, 32'h02010000, 32'h03020100, 32'h04030201,
                32'h00040302, 32'h00000403, 32'h00000004, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_en  = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011,
                4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0};
    for (int t = 0; t < 4; t++) begin
      in_v[t] = 1'b1;
      in_d[t] = 32'h01010101 * (t + 1);
    end
    run_stream("skew", 10, 8, 3);

    // 4: one-cycle bubble, then surplus vectors beyond the count
    load_fast(8'd4);
    clear_table();
    exp_col = '{0, 32'h01000000, 32'h02010000, 32'h00020100, 32'h03000201,
                32'h04030002, 32'h00040300, 32'h00000403, 32'h00000004, 0, 0,
                0, 0, 0, 0, 0};
    exp_en  = '{4'b0000, 4'b1000, 4'b1100, 4'b0110, 4'b1011, 4'b1101, 4'b0110,
                4'b0011, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
    in_v[0] = 1'b1; in_d[0] = 32'h01010101;
    in_v[1] = 1'b1; in_d[1] = 32'h02020202;
    in_v[2] = 1'b0; in_d[2] = 32'h77777777;
    in_v[3] = 1'b1; in_d[3] = 32'h03030303;
    in_v[4] = 1'b1; in_d[4] = 32'h04040404;
    for (int t = 5; t < 9; t++) begin
      in_v[t] = 1'b1;
      in_d[t] = 32'h05050505;
    end
    run_stream("bubble", 11, 9, 4);

    // 5: empty pass
    start_pass(8'd0);
    load_rows();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("empty%0d_preload", k), ifmap_preload_o, k == 0);
      check($sformatf("empty%0d_wen", k), weight_en_col_o, 0);
      check($sformatf("empty%0d_psen", k), psum_en_row_o, 0);
      check($sformatf("empty%0d_wready", k), weight_ready_o, 0);
      check($sformatf("empty%0d_done", k), done_o, k == 8);
      check($sformatf("empty%0d_busy", k), busy_o, k <= 8);
      cyc();
    end

    // 6a: start_i held during STREAM must not relatch the count
    load_fast(8'd2);
    clear_table();
    exp_col = '{0, 32'h01000000, 32'h02010000, 32'h00020100, 32'h00000201,
                32'h00000002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_en  = '{4'b0000, 4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001, 4'b0000,
                4'b0000, 0, 0, 0, 0, 0, 0, 0, 0};
    in_v[0] = 1'b1; in_d[0] = 32'h01010101;
    in_v[1] = 1'b1; in_d[1] = 32'h02020202;
    for (int t = 2; t < 6; t++) begin
      in_v[t] = 1'b1;
      in_d[t] = 32'h09090909;
    end
    for (int t = 0; t < 5; t++) in_s[t] = 1'b1;
    run_stream("busy_start", 8, 6, 1);
    check_quiet("after_start");

    // 6b: reset mid-STREAM abandons the pass silently
    load_fast(8'd4);
    weight_valid_i = 1'b1;
    weight_row_i   = 32'h01010101;
    cyc();
    check("rst_pre_col", weight_col_o, 32'h01000000);
    check("rst_pre_psen", psum_en_row_o, 4'b1111);
    weight_row_i = 32'h02020202;
    #2 rst_n = 1'b0;
    #1 check_quiet("rst_mid");
    @(negedge clk);
    rst_n          = 1'b1;
    weight_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("rst_after%0d_done", k), done_o, 0);
      check($sformatf("rst_after%0d_busy", k), busy_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
